// File: rtl/avion_pkg.sv
// Shared opcode map, FSM state encoding and instruction-field helper for the Avion v2 core.
package avion_pkg;

  localparam int unsigned OP_LOD = 0;
  localparam int unsigned OP_STO = 1;
  localparam int unsigned OP_ADD = 2;
  localparam int unsigned OP_SUB = 3;
  localparam int unsigned OP_MUL = 4;
  localparam int unsigned OP_DIV = 5;
  localparam int unsigned OP_JMP = 6;
  localparam int unsigned OP_JMZ = 7;
  localparam int unsigned OP_NOP = 8;
  localparam int unsigned OP_HLT = 9;
  localparam int unsigned OP_AND = 10;
  localparam int unsigned OP_OR  = 11;
  localparam int unsigned OP_XOR = 12;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_DIV_WAIT, S_HALT
  } state_e;

  // Extracts a width-bit field starting at lsb; callers narrow the result.
  function automatic logic [63:0] field(logic [63:0] w, int unsigned lsb, int unsigned width);
    return (w >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/avion_cpu_v2_if.sv
// Single-port synchronous RAM bus between the core (master) and the memory model (slave).
interface avion_cpu_v2_if #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
);
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_we;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/avion_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done/quotient are valid in the last step cycle.
module avion_divider #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic                  div_by_zero
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic                  busy_q, busy_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [DATA_WIDTH:0]   rem_sh;
  logic                  fits;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
    fits     = rem_sh >= {1'b0, dvs_q};
    // Next quotient is exposed combinationally so the core can latch it on the final step edge.
    quotient = {quo_q[DATA_WIDTH-2:0], fits};
    done     = busy_q && (cnt_q == CW'(1));
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(DATA_WIDTH);
      quo_d  = dividend;
      dvs_d  = divisor;
      rem_d  = '0;
    end else if (busy_q) begin
      rem_d = fits ? DATA_WIDTH'(rem_sh - {1'b0, dvs_q}) : DATA_WIDTH'(rem_sh);
      quo_d = quotient;
      cnt_d = cnt_q - CW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  assign div_by_zero = (dvs_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
    end
  end
endmodule

// File: rtl/avion_cpu_v2.sv
// Avion v2 accumulator CPU: FETCH/DECODE/EXEC/MEM sequencer over a one-cycle-latency RAM.
// Define AVION_CPU_DIV_EN to build the iterative divider and enable opcode DIV.
module avion_cpu_v2
  import avion_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 6,
  parameter int OPCODE_WIDTH  = 4,
  parameter int DATA_WIDTH    = ADDRESS_WIDTH + OPCODE_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  avion_cpu_v2_if.master           bus,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0]    acc,
  output logic                     carry,
  output logic                     halted,
  output logic                     illegal_op
);
  localparam int DW = DATA_WIDTH;
`ifdef AVION_CPU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, operand, addr;
  logic [DW-1:0]            ir_q, ir_d, acc_q, acc_d, rdata, wdata, div_quo;
  logic                     carry_q, carry_d, ill_q, ill_d, we, div_done, div_dbz;
  logic [OPCODE_WIDTH-1:0]  opcode;
  int unsigned              op;
  logic [DW:0]              sum;
  logic [2*DW-1:0]          prod;

  assign rdata   = bus.mem_rdata;
  assign opcode  = OPCODE_WIDTH'(field(64'(ir_q), ADDRESS_WIDTH, OPCODE_WIDTH));
  assign operand = ADDRESS_WIDTH'(field(64'(ir_q), 0, ADDRESS_WIDTH));
  assign op      = 32'(opcode);
  assign sum     = {1'b0, acc_q} + {1'b0, rdata};
  assign prod    = {{DW{1'b0}}, acc_q} * {{DW{1'b0}}, rdata};

`ifdef AVION_CPU_DIV_EN
  logic div_start;
  assign div_start = (state_q == S_MEM) && (op == OP_DIV) && !rst;
  avion_divider #(.DATA_WIDTH(DW)) u_div (
    .clk(clk), .rst(rst), .start(div_start), .dividend(acc_q), .divisor(rdata),
    .done(div_done), .quotient(div_quo), .div_by_zero(div_dbz)
  );
`else
  assign div_done = 1'b0;
  assign div_quo  = '0;
  assign div_dbz  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ill_d   = ill_q;
    addr    = '0;
    wdata   = '0;
    we      = 1'b0;
    case (state_q)
      S_FETCH: begin
        addr    = pc_q;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = rdata;
        pc_d    = pc_q + ADDRESS_WIDTH'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_LOD, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
            addr    = operand;
            state_d = S_MEM;
          end
          OP_DIV: begin
            if (DIV_EN) begin
              addr    = operand;
              state_d = S_MEM;
            end else begin
              ill_d   = 1'b1;
              state_d = S_HALT;
            end
          end
          OP_STO: begin
            addr  = operand;
            wdata = acc_q;
            we    = 1'b1;
          end
          OP_JMP: pc_d = operand;
          OP_JMZ: if (acc_q == '0) pc_d = operand;
          OP_NOP: ;
          OP_HLT: state_d = S_HALT;
          default: begin
            ill_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        state_d = S_FETCH;
        case (op)
          OP_LOD: acc_d = rdata;
          OP_ADD: {carry_d, acc_d} = sum;
          OP_SUB: begin
            acc_d   = acc_q - rdata;
            carry_d = rdata > acc_q;
          end
          OP_MUL: begin
            acc_d   = prod[DW-1:0];
            carry_d = |prod[2*DW-1:DW];
          end
          OP_AND: acc_d = acc_q & rdata;
          OP_OR:  acc_d = acc_q | rdata;
          OP_XOR: acc_d = acc_q ^ rdata;
          OP_DIV: state_d = S_DIV_WAIT;
          default: ;
        endcase
      end
      S_DIV_WAIT: begin
        if (div_done) begin
          acc_d   = div_quo;
          carry_d = div_dbz;
          state_d = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
    // Bus is quiet for the whole reset cycle, even if the FSM was mid-store.
    if (rst) begin
      addr  = '0;
      wdata = '0;
      we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_we    = we;
  assign pc            = pc_q;
  assign acc           = acc_q;
  assign carry         = carry_q;
  assign halted        = (state_q == S_HALT);
  assign illegal_op    = ill_q;
endmodule

// File: doc/avion_cpu_v2.md
Name: avion_cpu_v2

Overview:
Parametrised next-generation accumulator CPU for the Avion family. It fetches, decodes and executes single-address instructions from a synchronous single-port RAM with one-cycle read latency. Compared with the first-generation core it generalises the opcode and address widths, and adds SUB, logic ops, a carry flag, a real HALT state and illegal-opcode trapping. An optional iterative divider provides DIV. It sits between the testbench/top and the blram-style memory model.

Parameters:
ADDRESS_WIDTH, 6, operand/PC width; memory depth is 2**ADDRESS_WIDTH.
OPCODE_WIDTH, 4, opcode field width; must be >= 4.
DATA_WIDTH, ADDRESS_WIDTH+OPCODE_WIDTH, memory word and ACC width; must equal OPCODE_WIDTH+ADDRESS_WIDTH.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
mem_rdata  in  DATA_WIDTH  RAM read data; valid one cycle after mem_addr is presented.
mem_addr  out  ADDRESS_WIDTH  RAM address (combinational from state).
mem_wdata  out  DATA_WIDTH  RAM write data.
mem_we  out  1  RAM write enable, one-cycle pulse.
pc  out  ADDRESS_WIDTH  program counter.
acc  out  DATA_WIDTH  accumulator.
carry  out  1  carry/borrow flag.
halted  out  1  high while in HALT.
illegal_op  out  1  sticky; set when an undefined opcode traps.

Behaviour:
- Instruction word: IR[DATA_WIDTH-1 -: OPCODE_WIDTH] is the opcode; IR[ADDRESS_WIDTH-1:0] is the operand address.
- Opcodes: 0 LOD, 1 STO, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 JMP, 7 JMZ, 8 NOP, 9 HLT, 10 AND, 11 OR, 12 XOR. All others are illegal.
- Reset (rst high at an edge): state=FETCH, pc=0, ir=0, acc=0, carry=0, illegal_op=0.
  - mem_we=0, mem_addr=0, mem_wdata=0 while rst is high.
  - rst overrides any state, including DIV_WAIT and HALT.
- States: FETCH, DECODE, EXEC, MEM, DIV_WAIT, HALT.
- FETCH: mem_addr=pc. Next state DECODE.
- DECODE: ir<=mem_rdata; pc<=pc+1, wrapping modulo 2**ADDRESS_WIDTH. Next state EXEC.
- EXEC:
  - LOD/ADD/SUB/MUL/DIV/AND/OR/XOR: mem_addr=operand. Next state MEM.
  - STO: mem_addr=operand, mem_wdata=acc, mem_we=1. Next state FETCH.
  - JMP: pc<=operand. Next state FETCH.
  - JMZ: pc<=operand if acc==0, else pc unchanged. Next state FETCH.
  - NOP: next state FETCH.
  - HLT: next state HALT.
  - Illegal opcode: illegal_op<=1. Next state HALT.
- MEM (mem_rdata holds the operand):
  - LOD: acc<=rdata.
  - ADD: {carry,acc}<=acc+rdata.
  - SUB: acc<=acc-rdata; carry<=(rdata>acc), i.e. borrow.
  - MUL: acc<=low DATA_WIDTH bits of acc*rdata; carry<=1 if the high half is nonzero.
  - AND/OR/XOR: bitwise; carry unchanged.
  - DIV: start the divider. Next state DIV_WAIT.
  - All other MEM operations: next state FETCH.
- Instruction cycle counts: LOD/ALU ops 4; STO/JMP/JMZ/NOP 3; DIV 4+DATA_WIDTH.
- HALT: halted=1, mem_we=0. pc, acc and carry are frozen. Only rst leaves HALT.
- mem_we is never high outside EXEC of STO.

Optional Feature:
AVION_CPU_DIV_EN:
- Defined: opcode 5 (DIV) computes acc<=acc/rdata (unsigned) with a restoring divider, one quotient bit per cycle for DATA_WIDTH cycles in DIV_WAIT, then returns to FETCH.
  - Divide by zero: acc<=all ones, carry<=1.
  - Otherwise carry<=0.
- Undefined: opcode 5 is illegal (sets illegal_op, enters HALT); the divider is not instantiated.

Decomposition:
- Package avion_pkg holds:
  - opcode localparams: OP_LOD ... OP_XOR.
  - state encoding: S_FETCH ... S_HALT.
  - helper functions for opcode/operand field extraction.
- Sub-module avion_divider: start/done handshake, DATA_WIDTH-parametrised restoring divider. Instantiated only under AVION_CPU_DIV_EN.

Test Plan:
- Program: LOD 50; MUL 51; STO 52; HLT, with mem[50]=5, mem[51]=10 -> mem[52]=50, halted=1 at cycle 14, carry=0.
- LOD 50; SUB 51; STO 52; HLT with mem[50]=3, mem[51]=5, DATA_WIDTH=10 -> mem[52]=1022, carry=1.
- Loop program summing 5 ten times via JMZ/JMP counter -> mem[52]=50; pc holds after HLT; mem_we stays 0 for 100 further cycles.
- DIV_EN defined:
  - LOD 50; DIV 51 with 50/7 -> acc=7 after 14 cycles.
  - Divisor 0 -> acc=1023, carry=1.
  - Macro undefined -> illegal_op=1, halted=1.
- Opcode 15 in memory[0] -> illegal_op=1, halted=1, no write pulse; rst then clears both flags and pc=0.
- Assert rst during DIV_WAIT and again during the EXEC of STO -> no mem_we pulse; state FETCH, pc=0, acc=0 on the next edge.
- JMP 63 where mem[63]=NOP -> pc wraps to 0 after the fetch from 63.
